wb_trace_capture: RTL and testbench
===================================

# wb_trace_capture

Synthesizable writeback trace buffer that sits on the observation end of the pipelined datapath's `ProgramCounter`/`WriteData` outputs. It consumes the retirement stream that the top level produces, arms on request, triggers on a programmed PC, and captures a fixed-length window of (PC, write data) pairs into a FIFO. A valid/ready read port lets a bench, debug UART or on-chip checker drain the captured window.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `CAP_LEN`, 16: samples written per trigger, 1..65535.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `ProgramCounter`  in  32: datapath PC.
- `WriteData`  in  32: datapath writeback data.
- `arm`  in  1: one-cycle pulse; flush FIFO, enter ARMED.
- `trig_pc`  in  32: trigger PC; sampled on each sample event while ARMED.
- `rd_valid`  out  1: head entry available.
- `rd_ready`  in  1: consumer accepts head.
- `rd_pc`  out  32: head entry PC.
- `rd_data`  out  32: head entry write data.
- `state`  out  2: current FSM state encoding.
- `overflow`  out  1: sticky; a sample was dropped because the FIFO was full.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Sample event: `ProgramCounter != pc_q`, where `pc_q` is the PC registered every cycle (reset 0). The sample is {`ProgramCounter`, `WriteData`} from the same cycle.
- States: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
  - IDLE: no writes. `arm` → ARMED.
  - ARMED: no writes. A sample with PC == `trig_pc` writes that sample, loads the capture counter with 1 and moves to CAPTURE; if `CAP_LEN`==1 it moves straight to DONE.
  - CAPTURE: each sample is written and the counter increments. When the counter reaches `CAP_LEN` → DONE.
  - DONE: no writes. FIFO empty → IDLE.
- `arm` in any state flushes the FIFO, clears `overflow` and the counter, and enters ARMED. `arm` wins over a same-cycle trigger or write.
- FIFO full with a sample in CAPTURE and no pop in the same cycle: the sample is dropped, `overflow` is set and the counter still increments, so the window stays time-bounded.
- Full, with a sample and a pop in the same cycle: both take effect and the level is unchanged.
- Reads are legal in every state. Pop happens when `rd_valid && rd_ready`.
- `rd_pc`/`rd_data` hold the head entry and are undefined-but-stable while `rd_valid`=0.
- Pointers wrap modulo `DEPTH`. `level` is the write count minus the read count.

## Timing
- Reset values: `state`=IDLE, `rd_valid`=0, `rd_pc`=0, `rd_data`=0, `overflow`=0, `level`=0, `pc_q`=0, counter 0, pointers 0.
- Write latency: a sample at edge k is written at edge k, and `rd_valid` rises after edge k when the FIFO was previously empty (first-word fall-through, 1 cycle).
- Pop at edge k: the next head or `rd_valid`=0 is visible after edge k. A sustained `rd_ready` gives 1 entry/cycle.
- Empty with a same-cycle write: no pop, because `rd_valid` was 0.
- State transitions take effect at the edge of the causing event. DONE→IDLE happens at the edge after `level` reaches 0.
- `rst` asserted mid-capture clears everything immediately, asynchronously. Captured data is lost.

## Configuration
- `TRACE_TIMESTAMP_EN` defined:
  - A 32-bit free-running cycle counter (reset 0, wraps) is stored with each entry.
  - Extra output `rd_ts` [31:0] presents the head entry's timestamp, i.e. the counter value in the write cycle.
- Undefined: no counter, no `rd_ts` port, entry width 64 bits.

## Structure
- Package `trace_pkg`:
  - `trace_state_t` enum (IDLE/ARMED/CAPTURE/DONE).
  - `trace_entry_t` struct (pc, data, optional ts).
  - State encoding constants.
- Sub-module `trace_fifo`: parameterized first-word-fall-through synchronous FIFO with push/pop/flush, full/empty/level. The top holds the FSM, sample detect, counter and timestamp.

## Test plan
- Reset then idle: PC steps 0,4,8 with no `arm` → `rd_valid`=0, `level`=0, `state`=0 throughout.
- Arm, `trig_pc`=0x10, `CAP_LEN`=4, PC sequence 0x0C,0x10,0x14,0x18,0x1C,0x20 with `rd_ready`=0 → entries 0x10..0x1C with matching data, `state`=DONE, `level`=4, 0x20 absent.
- Drain the previous case with `rd_ready`=1 → 4 consecutive pops in 4 cycles in order, then `state`=IDLE on the next edge.
- `DEPTH`=4, `CAP_LEN`=6, `rd_ready`=0 → 4 entries kept, `overflow`=1, DONE. Then `arm` → `level`=0, `overflow`=0, ARMED.
- Full FIFO in CAPTURE with a sample and `rd_ready`=1 in the same cycle → `level` unchanged, no overflow, new sample at the tail.
- `rst` pulsed mid-CAPTURE → all outputs return to reset values asynchronously. With `TRACE_TIMESTAMP_EN`, `rd_ts` for consecutive samples one cycle apart differs by 1.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the writeback trace capture block.
// Optional macro: TRACE_TIMESTAMP_EN adds a per-entry cycle timestamp.
package trace_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TS_W   = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_ARMED   = ST_ARMED,
    S_CAPTURE = ST_CAPTURE,
    S_DONE    = ST_DONE
  } trace_state_t;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through synchronous FIFO of trace entries with flush.
// Pointers carry one extra wrap bit so level = wr_ptr - rd_ptr.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  trace_entry_t           wr_entry,
  output trace_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  trace_entry_t  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; flush discards contents but leaves storage as is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wr_entry;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/wb_trace_capture.sv
// Writeback trace buffer: arms, triggers on a PC, captures CAP_LEN samples.
// Optional macro: TRACE_TIMESTAMP_EN adds a free-running cycle timestamp and rd_ts.
module wb_trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CAP_LEN = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_W-1:0]        ProgramCounter,
  input  logic [DATA_W-1:0]      WriteData,
  input  logic                   arm,
  input  logic [PC_W-1:0]        trig_pc,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [PC_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]      rd_data,
  output logic [1:0]             state,
  output logic                   overflow,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]        rd_ts,
`endif
  output logic [$clog2(DEPTH):0] level
);

  localparam logic [CNT_W-1:0] CAP_LEN_C = CNT_W'(CAP_LEN);

  trace_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [PC_W-1:0]   pc_q;
  logic              sample;
  logic              push;
  logic              flush;
  logic              pop;
  logic              full;
  logic              empty;
  trace_entry_t      wr_entry;
  trace_entry_t      head;

  assign sample   = (ProgramCounter != pc_q);
  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;
  assign rd_pc    = head.pc;
  assign rd_data  = head.data;
  assign state    = state_q;
  assign overflow = ovf_q;

  assign wr_entry.pc   = ProgramCounter;
  assign wr_entry.data = WriteData;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running cycle counter stamped onto each written entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + TS_W'(1);
  end

  assign wr_entry.ts = ts_q;
  assign rd_ts       = head.ts;
`endif

  // Previous-cycle PC for sample detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else     pc_q <= ProgramCounter;
  end

  // FSM, capture counter and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state, write request and overflow detection; arm overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (arm) begin
      flush   = 1'b1;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = S_ARMED;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ARMED: begin
          if (sample && (ProgramCounter == trig_pc)) begin
            push    = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = (CAP_LEN == 1) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (sample) begin
            push  = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CAP_LEN_C) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (empty) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (push && full && !pop) ovf_d = 1'b1;
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

endmodule

// File: tb/tb_wb_trace_capture.sv
// Directed bench for wb_trace_capture: instance A (DEPTH 16, CAP_LEN 4) runs the
// vector table; instance B (DEPTH 4, CAP_LEN 6) covers overflow and full+pop.
module tb_wb_trace_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic [31:0] wd_in = '0;
  logic [31:0] trig  = 32'h10;
  logic        arm_a = 1'b0, arm_b = 1'b0;
  logic        rdy_a = 1'b0, rdy_b = 1'b0;

  logic        valid_a, valid_b;
  logic [31:0] rpc_a, rpc_b, rdat_a, rdat_b;
  logic [1:0]  st_a, st_b;
  logic        ovf_a, ovf_b;
  logic [4:0]  lvl_a;
  logic [2:0]  lvl_b;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_a, ts_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_trace_capture #(.DEPTH(16), .CAP_LEN(4)) u_a (
    .clk(clk), .rst(rst), .ProgramCounter(pc_in), .WriteData(wd_in),
    .arm(arm_a), .trig_pc(trig), .rd_valid(valid_a), .rd_ready(rdy_a),
    .rd_pc(rpc_a), .rd_data(rdat_a), .state(st_a), .overflow(ovf_a),
`ifdef TRACE_TIMESTAMP_EN
    .rd_ts(ts_a),
`endif
    .level(lvl_a)
  );

  wb_trace_capture #(.DEPTH(4), .CAP_LEN(6)) u_b (
    .clk(clk), .rst(rst), .ProgramCounter(pc_in), .WriteData(wd_in),
    .arm(arm_b), .trig_pc(trig), .rd_valid(valid_b), .rd_ready(rdy_b),
    .rd_pc(rpc_b), .rd_data(rdat_b), .state(st_b), .overflow(ovf_b),
`ifdef TRACE_TIMESTAMP_EN
    .rd_ts(ts_b),
`endif
    .level(lvl_b)
  );

  function automatic logic [31:0] dfun(input logic [31:0] pc);
    return (pc << 4) ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic [31:0] pc, input logic aa, input logic ra,
                      input logic ab, input logic rb);
    @(negedge clk);
    pc_in = pc;
    wd_in = dfun(pc);
    arm_a = aa;
    rdy_a = ra;
    arm_b = ab;
    rdy_b = rb;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        arm;
    logic        rdy;
    logic        ev;
    int          el;
    logic [1:0]  es;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs [15];
  logic [31:0] drain_exp [4];
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts0;
`endif

  initial begin
    // pc, arm, rdy | valid, level, state, head pc
    vecs[0]  = '{32'h00, 1'b0, 1'b0, 1'b0, 0, 2'd0, 32'h0};
    vecs[1]  = '{32'h04, 1'b0, 1'b0, 1'b0, 0, 2'd0, 32'h0};
    vecs[2]  = '{32'h08, 1'b0, 1'b0, 1'b0, 0, 2'd0, 32'h0};
    vecs[3]  = '{32'h08, 1'b1, 1'b0, 1'b0, 0, 2'd1, 32'h0};
    vecs[4]  = '{32'h0C, 1'b0, 1'b0, 1'b0, 0, 2'd1, 32'h0};
    vecs[5]  = '{32'h10, 1'b0, 1'b0, 1'b1, 1, 2'd2, 32'h10};
    vecs[6]  = '{32'h14, 1'b0, 1'b0, 1'b1, 2, 2'd2, 32'h10};
    vecs[7]  = '{32'h18, 1'b0, 1'b0, 1'b1, 3, 2'd2, 32'h10};
    vecs[8]  = '{32'h1C, 1'b0, 1'b0, 1'b1, 4, 2'd3, 32'h10};
    vecs[9]  = '{32'h20, 1'b0, 1'b0, 1'b1, 4, 2'd3, 32'h10};
    vecs[10] = '{32'h20, 1'b0, 1'b1, 1'b1, 3, 2'd3, 32'h14};
    vecs[11] = '{32'h20, 1'b0, 1'b1, 1'b1, 2, 2'd3, 32'h18};
    vecs[12] = '{32'h20, 1'b0, 1'b1, 1'b1, 1, 2'd3, 32'h1C};
    vecs[13] = '{32'h20, 1'b0, 1'b1, 1'b0, 0, 2'd3, 32'h0};
    vecs[14] = '{32'h20, 1'b0, 1'b0, 1'b0, 0, 2'd0, 32'h0};

    // Reset values
    #12;
    chk("rst_valid_a", 32'(valid_a), 32'd0);
    chk("rst_level_a", 32'(lvl_a), 32'd0);
    chk("rst_state_a", 32'(st_a), 32'd0);
    chk("rst_rdpc_a", rpc_a, 32'd0);
    chk("rst_rddata_a", rdat_a, 32'd0);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    chk("rst_state_b", 32'(st_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle, arm, trigger, capture, drain on instance A
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].pc, vecs[i].arm, vecs[i].rdy, 1'b0, 1'b0);
      chk($sformatf("v%0d_valid", i), 32'(valid_a), 32'(vecs[i].ev));
      chk($sformatf("v%0d_level", i), 32'(lvl_a), 32'(vecs[i].el));
      chk($sformatf("v%0d_state", i), 32'(st_a), 32'(vecs[i].es));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_rdpc", i), rpc_a, vecs[i].epc);
        chk($sformatf("v%0d_rddata", i), rdat_a, dfun(vecs[i].epc));
      end
    end
    chk("b_idle_state", 32'(st_b), 32'd0);
    chk("b_idle_level", 32'(lvl_b), 32'd0);

    // Overflow on instance B (DEPTH 4, CAP_LEN 6)
    step(32'h30, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_armed", 32'(st_b), 32'd1);
    step(32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_trig_state", 32'(st_b), 32'd2);
    step(32'h14, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h18, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_full_level", 32'(lvl_b), 32'd4);
    chk("ovf_full_noovf", 32'(ovf_b), 32'd0);
    step(32'h24, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf_b), 32'd1);
    chk("ovf_level5", 32'(lvl_b), 32'd4);
    chk("ovf_state5", 32'(st_b), 32'd2);
    step(32'h28, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_done", 32'(st_b), 32'd3);
    chk("ovf_level6", 32'(lvl_b), 32'd4);
    chk("ovf_head", rpc_b, 32'h10);
    step(32'h28, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rearm_level", 32'(lvl_b), 32'd0);
    chk("rearm_ovf", 32'(ovf_b), 32'd0);
    chk("rearm_state", 32'(st_b), 32'd1);
    chk("rearm_valid", 32'(valid_b), 32'd0);

    // Full FIFO with a sample and a pop in the same cycle
    step(32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h14, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h18, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fp_pre_level", 32'(lvl_b), 32'd4);
    step(32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fp_level", 32'(lvl_b), 32'd4);
    chk("fp_noovf", 32'(ovf_b), 32'd0);
    chk("fp_state", 32'(st_b), 32'd2);
    drain_exp[0] = 32'h14;
    drain_exp[1] = 32'h18;
    drain_exp[2] = 32'h1C;
    drain_exp[3] = 32'h40;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fp_drain%0d_pc", i), rpc_b, drain_exp[i]);
      chk($sformatf("fp_drain%0d_data", i), rdat_b, dfun(drain_exp[i]));
      step(32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("fp_empty_valid", 32'(valid_b), 32'd0);
    chk("fp_empty_level", 32'(lvl_b), 32'd0);

    // Asynchronous reset in the middle of a capture
    step(32'h44, 1'b0, 1'b0, 1'b1, 1'b0);
    step(32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h14, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("prerst_level", 32'(lvl_b), 32'd2);
    chk("prerst_state", 32'(st_b), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(st_b), 32'd0);
    chk("arst_valid", 32'(valid_b), 32'd0);
    chk("arst_level", 32'(lvl_b), 32'd0);
    chk("arst_rdpc", rpc_b, 32'd0);
    chk("arst_rddata", rdat_b, 32'd0);
    chk("arst_ovf", 32'(ovf_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef TRACE_TIMESTAMP_EN
    // Consecutive samples one cycle apart carry timestamps that differ by one
    step(32'h0C, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h14, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ts_level", 32'(lvl_a), 32'd2);
    ts0 = ts_a;
    step(32'h14, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ts_next_pc", rpc_a, 32'h14);
    chk("ts_delta", ts_a, ts0 + 32'd1);
    step(32'h14, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
